// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 mouse controller: transmitter states,
// common command/response bytes and the frame parity helper.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP,
    ACK,
    WAIT
  } tx_state_t;

  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_ACK        = 8'hFA;

  // PS/2 frames carry odd parity over the eight data bits
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock conditioning: two-flop synchroniser, FILTER_LEN-sample glitch
// filter and a one-cycle tick on each filtered falling edge.
module ps2_clk_filter
  import ps2_host_tx_pkg::*;
#(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c,
  output logic ps2c_filt,
  output logic fall_tick
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // the filtered level only follows after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync      <= 2'b11;
      ps2c_filt <= 1'b1;
      cnt       <= '0;
      fall_tick <= 1'b0;
    end else begin
      sync      <= {sync[0], ps2c};
      fall_tick <= 1'b0;
      if (sync[1] == ps2c_filt) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        ps2c_filt <= sync[1];
        cnt       <= '0;
        fall_tick <= ps2c_filt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter with open-collector line drivers.
// Define PS2_TX_TIMEOUT_EN to add a device-clock watchdog (TIMEOUT_CYCLES).
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FILTER_LEN     = 8
`ifdef PS2_TX_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);

  tx_state_t     state;
  logic [IW-1:0] inhibit_cnt;
  logic [8:0]    sreg;
  logic [3:0]    bit_cnt;
  logic          ps2c_low;
  logic          ps2d_low;
  logic          ps2c_filt;
  logic          fall_tick;
  logic [1:0]    ps2d_sync;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WW-1:0] wdog;
`endif

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .ps2c     (ps2c),
    .ps2c_filt(ps2c_filt),
    .fall_tick(fall_tick)
  );

  // reset gates the drivers so the bus is freed without waiting for a clock
  assign ps2c = (ps2c_low && !reset) ? 1'b0 : 1'bz;
  assign ps2d = (ps2d_low && !reset) ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ps2d_sync <= 2'b11;
    else       ps2d_sync <= {ps2d_sync[0], ps2d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      inhibit_cnt  <= '0;
      sreg         <= '0;
      bit_cnt      <= '0;
      ps2c_low     <= 1'b0;
      ps2d_low     <= 1'b0;
      tx_idle      <= 1'b1;
      tx_done_tick <= 1'b0;
      tx_err       <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wdog         <= '0;
`endif
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_ps2) begin
            sreg        <= {odd_parity(din), din};
            inhibit_cnt <= IW'(INHIBIT_CYCLES - 1);
            bit_cnt     <= '0;
            tx_err      <= 1'b0;
            tx_idle     <= 1'b0;
            ps2c_low    <= 1'b1;
            state       <= RTS;
          end
        end
        RTS: begin
          if (inhibit_cnt == '0) begin
            ps2c_low <= 1'b0;
            ps2d_low <= 1'b1;
            state    <= START;
          end else begin
            inhibit_cnt <= inhibit_cnt - 1'b1;
          end
        end
        START: begin
          if (fall_tick) begin
            ps2d_low <= ~sreg[0];
            state    <= DATA;
          end
        end
        // nine falls here: data bits 0..7 then parity, then the line is freed
        DATA: begin
          if (fall_tick) begin
            if (bit_cnt == 4'd8) begin
              ps2d_low <= 1'b0;
              state    <= STOP;
            end else begin
              sreg     <= {1'b0, sreg[8:1]};
              ps2d_low <= ~sreg[1];
              bit_cnt  <= bit_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (fall_tick) state <= ACK;
        end
        ACK: begin
          if (fall_tick) begin
            tx_err <= ps2d_sync[1];
            state  <= WAIT;
          end
        end
        WAIT: begin
          if (ps2c_filt && ps2d_sync[1]) begin
            tx_idle      <= 1'b1;
            tx_done_tick <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

`ifdef PS2_TX_TIMEOUT_EN
      // a silent device aborts the transfer as a failed command
      if (state inside {START, DATA, STOP, ACK}) begin
        if (fall_tick) begin
          wdog <= '0;
        end else if (wdog == WW'(TIMEOUT_CYCLES - 1)) begin
          wdog         <= '0;
          ps2c_low     <= 1'b0;
          ps2d_low     <= 1'b0;
          tx_idle      <= 1'b1;
          tx_done_tick <= 1'b1;
          tx_err       <= 1'b1;
          state        <= IDLE;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end else begin
        wdog <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2 device on pulled-up lines.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  wire        ps2c;
  wire        ps2d;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       tx_err;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic last_err = 1'b0;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_clk ? 1'bz : 1'b0;
  assign ps2d = dev_dat ? 1'bz : 1'b0;

  always #10 clk = ~clk;

`ifdef PS2_TX_TIMEOUT_EN
  ps2_host_tx #(.TIMEOUT_CYCLES(2000)) dut (
`else
  ps2_host_tx dut (
`endif
    .clk         (clk),
    .reset       (reset),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err      (tx_err)
  );

  always @(negedge clk) begin
    if (tx_done_tick) begin
      done_cnt++;
      last_err = tx_err;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    @(negedge clk);
    din    = b;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
  endtask

  // device side: time the inhibit pulse, clock out 11 bits, then optionally ACK
  task automatic run_device(input bit ack, input bit glitch, input bit wr_mid, input int reset_at,
                            output logic [10:0] frame, output int low_cnt);
    int wait_cnt;
    frame    = '0;
    low_cnt  = 0;
    wait_cnt = 0;
    while (ps2c !== 1'b0 && wait_cnt < 100) begin
      @(negedge clk);
      wait_cnt++;
    end
    while (ps2c === 1'b0 && low_cnt < 20000) begin
      low_cnt++;
      @(negedge clk);
    end
    repeat (60) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      frame[i] = ps2d;
      dev_clk  = 1'b0;
      if (wr_mid && i == 3) begin
        @(negedge clk);
        din    = 8'h00;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      dev_clk = 1'b1;
      if (reset_at == i) begin
        @(negedge clk);
        check_output("rst_pre_ps2d", ps2d, 0);
        reset = 1'b1;
        #1;
        check_output("rst_ps2c", ps2c, 1);
        check_output("rst_ps2d", ps2d, 1);
        check_output("rst_idle", tx_idle, 1);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (glitch && i == 4) begin
        repeat (25) @(negedge clk);
        dev_clk = 1'b0;
        repeat (3) @(negedge clk);
        dev_clk = 1'b1;
        repeat (HALF - 28) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    if (ack) dev_dat = 1'b0;
    repeat (10) @(negedge clk);
    dev_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    dev_clk = 1'b1;
    repeat (20) @(negedge clk);
    dev_dat = 1'b1;
  endtask

  task automatic run_transfer(input string tag, input logic [7:0] b, input logic exp_parity,
                              input bit ack, input bit glitch, input bit wr_mid);
    logic [10:0] frame;
    int          low_cnt;
    int          d0;
    d0 = done_cnt;
    apply_stimulus(b);
    run_device(ack, glitch, wr_mid, -1, frame, low_cnt);
    repeat (50) @(negedge clk);
    check_output({tag, "_rts_low"}, low_cnt, 5000);
    check_output({tag, "_frame"}, {21'd0, frame}, {21'd0, 1'b1, exp_parity, b, 1'b0});
    check_output({tag, "_done"}, done_cnt - d0, 1);
    check_output({tag, "_err"}, last_err, ack ? 0 : 1);
    check_output({tag, "_idle"}, tx_idle, 1);
    check_output({tag, "_ps2c_rel"}, ps2c, 1);
  endtask

  initial begin
    logic [10:0] frame;
    int          low_cnt;
    int          d0;

    $display("[TB] start");
    repeat (5) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_output("reset_ps2c", ps2c, 1);
    check_output("reset_ps2d", ps2d, 1);
    check_output("reset_idle", tx_idle, 1);
    check_output("reset_done", tx_done_tick, 0);
    check_output("reset_err", tx_err, 0);

    run_transfer("f4", PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b0, 1'b0);
    run_transfer("ff", PS2_CMD_RESET, 1'b1, 1'b1, 1'b0, 1'b0);
    run_transfer("00", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_transfer("noack", PS2_ACK, 1'b1, 1'b0, 1'b0, 1'b0);
    run_transfer("wrmid", PS2_CMD_ENABLE, 1'b0, 1'b1, 1'b0, 1'b1);
    run_transfer("glitch", PS2_CMD_RESET, 1'b1, 1'b1, 1'b1, 1'b0);

    // reset while the host is driving data bit 1 (0) of 8'hF4
    d0 = done_cnt;
    apply_stimulus(PS2_CMD_ENABLE);
    run_device(1'b1, 1'b0, 1'b0, 1, frame, low_cnt);
    check_output("rst_rts_low", low_cnt, 5000);
    check_output("rst_frame_head", {30'd0, frame[1:0]}, 0);
    repeat (100) @(negedge clk);
    check_output("rst_no_done", done_cnt - d0, 0);
    check_output("rst_after_idle", tx_idle, 1);
    check_output("rst_after_ps2c", ps2c, 1);

`ifdef PS2_TX_TIMEOUT_EN
    begin
      int wait_cnt;
      int tcnt;
      apply_stimulus(PS2_CMD_ENABLE);
      wait_cnt = 0;
      while (ps2c === 1'b0 && wait_cnt < 20000) begin
        @(negedge clk);
        wait_cnt++;
      end
      tcnt = 0;
      while (tx_done_tick !== 1'b1 && tcnt < 5000) begin
        @(negedge clk);
        tcnt++;
      end
      check_output("tmo_cycles", tcnt, 2000);
      check_output("tmo_err", tx_err, 1);
      check_output("tmo_idle", tx_idle, 1);
      @(negedge clk);
      check_output("tmo_ps2d_rel", ps2d, 1);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
